pwm_regs_mc: RTL and testbench

Multi-channel, parametrised register bank for the PWM generator. Sits between the SPI/bus decoder and NUM_CH counter+PWM channel pairs. Each channel gets its own register window, with double-buffered period/compare values, a self-clearing counter-reset strobe, sticky W1C status and a masked interrupt. Read data is registered.

---
 rtl/pwm_regs_mc_if.sv | 14 +
 rtl/pwm_regs_mc.sv | 187 ++++++++++++++++++
 tb/tb_pwm_regs_mc.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_regs_mc_if.sv
// Decoder-side register bus of the multi-channel PWM register bank.
// read/write are single-cycle strobes with no backpressure; addr and data_write are
// valid during the strobe cycle, and data_read is valid from the edge after a read
// strobe and holds until the next read strobe.
interface pwm_regs_mc_if;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;

  modport master (output read, write, addr, data_write, input data_read);
  modport slave  (input read, write, addr, data_write, output data_read);
endinterface

// File: rtl/pwm_regs_mc.sv
// Per-channel register windows (addr[5:4] = channel) for NUM_CH counter+PWM pairs.
// Define PWM_REGS_SHADOW_EN to double-buffer period/compare behind staging registers.
module pwm_regs_mc #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pwm_regs_mc_if.slave            bus,
  input  logic [NUM_CH*CNT_W-1:0] counter_val,
  input  logic [NUM_CH-1:0]       period_evt,
  output logic [NUM_CH*CNT_W-1:0] period,
  output logic [NUM_CH*CNT_W-1:0] compare1,
  output logic [NUM_CH*CNT_W-1:0] compare2,
  output logic [NUM_CH-1:0]       en,
  output logic [NUM_CH-1:0]       count_reset,
  output logic [NUM_CH-1:0]       upnotdown,
  output logic [NUM_CH*8-1:0]     prescale,
  output logic [NUM_CH-1:0]       pwm_en,
  output logic [NUM_CH*8-1:0]     functions,
  output logic                    irq
);

  // Value index 0 = period, 1 = compare1, 2 = compare2.
  localparam int NV = 3;
  localparam logic [3:0] LO_OFF [NV] = '{4'h0, 4'h3, 4'h5};
  localparam logic [3:0] HI_OFF [NV] = '{4'h1, 4'h4, 4'h6};

  logic [CNT_W-1:0] act_q [NUM_CH][NV];
  logic [CNT_W-1:0] act_d [NUM_CH][NV];
`ifdef PWM_REGS_SHADOW_EN
  logic [CNT_W-1:0] stg_q [NUM_CH][NV];
  logic [CNT_W-1:0] stg_d [NUM_CH][NV];
`endif
  logic [NUM_CH-1:0] en_q, en_d, cr_q, cr_d, ud_q, ud_d, pwm_en_q, pwm_en_d;
  logic [7:0]        pre_q [NUM_CH];
  logic [7:0]        pre_d [NUM_CH];
  logic [7:0]        fn_q  [NUM_CH];
  logic [7:0]        fn_d  [NUM_CH];
  logic [1:0]        st_q  [NUM_CH];
  logic [1:0]        st_d  [NUM_CH];
  logic [1:0]        mask_q [NUM_CH];
  logic [1:0]        mask_d [NUM_CH];
  logic [7:0]        data_read_q, data_read_d;

  function automatic logic [CNT_W-1:0] wr_val(input logic [CNT_W-1:0] cur, input logic lo,
                                              input logic hi, input logic [7:0] b);
    logic [CNT_W-1:0] r;
    r = cur;
    if (lo) r[7:0] = b;
    if (hi) r[CNT_W-1:8] = b[CNT_W-9:0];
    return r;
  endfunction

  always_comb begin
    logic             wr_hit;
    logic [3:0]       off;
    logic [1:0]       st_set;
    logic [1:0]       st_clr;
    logic [7:0]       ch_rd;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] src [NV];
`ifdef PWM_REGS_SHADOW_EN
    logic             ld;
`endif
    off         = bus.addr[3:0];
    en_d        = en_q;
    cr_d        = '0;
    ud_d        = ud_q;
    pwm_en_d    = pwm_en_q;
    data_read_d = bus.read ? 8'h00 : data_read_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      wr_hit     = bus.write && (bus.addr[5:4] == 2'(ch));
      pre_d[ch]  = pre_q[ch];
      fn_d[ch]   = fn_q[ch];
      mask_d[ch] = mask_q[ch];
      st_set     = {1'b0, period_evt[ch]};
      st_clr     = (wr_hit && off == 4'hE) ? bus.data_write[1:0] : 2'b00;
      cnt        = counter_val[ch*CNT_W +: CNT_W];
`ifdef PWM_REGS_SHADOW_EN
      // A load copies the pre-write staging value, so a same-cycle write waits for the next trigger.
      ld        = !en_q[ch] || period_evt[ch] || cr_q[ch];
      st_set[1] = ld && en_q[ch];
`endif
      for (int v = 0; v < NV; v++) begin
`ifdef PWM_REGS_SHADOW_EN
        stg_d[ch][v] = wr_val(stg_q[ch][v], wr_hit && off == LO_OFF[v],
                              wr_hit && off == HI_OFF[v], bus.data_write);
        act_d[ch][v] = ld ? stg_q[ch][v] : act_q[ch][v];
        src[v]       = stg_q[ch][v];
`else
        act_d[ch][v] = wr_val(act_q[ch][v], wr_hit && off == LO_OFF[v],
                              wr_hit && off == HI_OFF[v], bus.data_write);
        src[v]       = act_q[ch][v];
`endif
      end
      st_d[ch] = (st_q[ch] & ~st_clr) | st_set;
      if (wr_hit) begin
        case (off)
          4'h2: en_d[ch]     = bus.data_write[0];
          4'h7: cr_d[ch]     = bus.data_write[0];
          4'hA: pre_d[ch]    = bus.data_write;
          4'hB: ud_d[ch]     = bus.data_write[0];
          4'hC: pwm_en_d[ch] = bus.data_write[0];
          4'hD: fn_d[ch]     = bus.data_write;
          4'hF: mask_d[ch]   = bus.data_write[1:0];
          default: ;
        endcase
      end
      case (off)
        4'h0:    ch_rd = src[0][7:0];
        4'h1:    ch_rd = 8'(src[0] >> 8);
        4'h2:    ch_rd = {7'b0, en_q[ch]};
        4'h3:    ch_rd = src[1][7:0];
        4'h4:    ch_rd = 8'(src[1] >> 8);
        4'h5:    ch_rd = src[2][7:0];
        4'h6:    ch_rd = 8'(src[2] >> 8);
        4'h8:    ch_rd = cnt[7:0];
        4'h9:    ch_rd = 8'(cnt >> 8);
        4'hA:    ch_rd = pre_q[ch];
        4'hB:    ch_rd = {7'b0, ud_q[ch]};
        4'hC:    ch_rd = {7'b0, pwm_en_q[ch]};
        4'hD:    ch_rd = fn_q[ch];
        4'hE:    ch_rd = {6'b0, st_q[ch]};
        4'hF:    ch_rd = {6'b0, mask_q[ch]};
        default: ch_rd = 8'h00;
      endcase
      if (bus.read && bus.addr[5:4] == 2'(ch)) data_read_d = ch_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        for (int v = 0; v < NV; v++) begin
          act_q[ch][v] <= '0;
`ifdef PWM_REGS_SHADOW_EN
          stg_q[ch][v] <= '0;
`endif
        end
        pre_q[ch]  <= '0;
        fn_q[ch]   <= '0;
        st_q[ch]   <= '0;
        mask_q[ch] <= '0;
      end
      en_q        <= '0;
      cr_q        <= '0;
      ud_q        <= '1;
      pwm_en_q    <= '0;
      data_read_q <= '0;
    end else begin
      act_q       <= act_d;
`ifdef PWM_REGS_SHADOW_EN
      stg_q       <= stg_d;
`endif
      pre_q       <= pre_d;
      fn_q        <= fn_d;
      st_q        <= st_d;
      mask_q      <= mask_d;
      en_q        <= en_d;
      cr_q        <= cr_d;
      ud_q        <= ud_d;
      pwm_en_q    <= pwm_en_d;
      data_read_q <= data_read_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign period[g*CNT_W +: CNT_W]   = act_q[g][0];
    assign compare1[g*CNT_W +: CNT_W] = act_q[g][1];
    assign compare2[g*CNT_W +: CNT_W] = act_q[g][2];
    assign prescale[g*8 +: 8]         = pre_q[g];
    assign functions[g*8 +: 8]        = fn_q[g];
  end

  assign en            = en_q;
  assign count_reset   = cr_q;
  assign upnotdown     = ud_q;
  assign pwm_en        = pwm_en_q;
  assign bus.data_read = data_read_q;

  always_comb begin
    irq = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) irq = irq | (|(st_q[ch] & mask_q[ch]));
  end

endmodule

// File: tb/tb_pwm_regs_mc.sv
// Directed then randomized bench for pwm_regs_mc (NUM_CH=2, CNT_W=12) against a
// cycle-level register model; follows PWM_REGS_SHADOW_EN when it is defined.
module tb_pwm_regs_mc;
  localparam int NC   = 2;
  localparam int CW   = 12;
  localparam int MASK = (1 << CW) - 1;
`ifdef PWM_REGS_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NC*CW-1:0] counter_val, period, compare1, compare2;
  logic [NC-1:0]    period_evt, en, count_reset, upnotdown, pwm_en;
  logic [NC*8-1:0]  prescale, functions;
  logic             irq;
  int               n_chk = 0;
  int               n_pass = 0;
  int               n_fail = 0;

  pwm_regs_mc_if bus ();

  pwm_regs_mc #(.NUM_CH(NC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .counter_val(counter_val),
    .period_evt(period_evt), .period(period), .compare1(compare1), .compare2(compare2),
    .en(en), .count_reset(count_reset), .upnotdown(upnotdown), .prescale(prescale),
    .pwm_en(pwm_en), .functions(functions), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers per channel; value index 0 period, 1 cmp1, 2 cmp2.
  int m_stg [NC][3];
  int m_act [NC][3];
  int m_en [NC], m_cr [NC], m_ud [NC], m_pwm [NC], m_pre [NC], m_fn [NC], m_st [NC], m_mask [NC];
  int m_rd;

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      for (int v = 0; v < 3; v++) begin
        m_stg[k][v] = 0;
        m_act[k][v] = 0;
      end
      m_en[k] = 0; m_cr[k] = 0; m_ud[k] = 1; m_pwm[k] = 0;
      m_pre[k] = 0; m_fn[k] = 0; m_st[k] = 0; m_mask[k] = 0;
    end
    m_rd = 0;
  endtask

  function automatic int visible(int c, int v);
    return SHADOW ? m_stg[c][v] : m_act[c][v];
  endfunction

  function automatic int m_read(int c, int off);
    int cv;
    cv = int'(counter_val >> (c * CW)) & MASK;
    case (off)
      0: return visible(c, 0) % 256;
      1: return visible(c, 0) / 256;
      2: return m_en[c];
      3: return visible(c, 1) % 256;
      4: return visible(c, 1) / 256;
      5: return visible(c, 2) % 256;
      6: return visible(c, 2) / 256;
      8: return cv % 256;
      9: return cv / 256;
      10: return m_pre[c];
      11: return m_ud[c];
      12: return m_pwm[c];
      13: return m_fn[c];
      14: return m_st[c];
      15: return m_mask[c];
      default: return 0;
    endcase
  endfunction

  task automatic m_wr(int c, int v, bit hi, int b);
    int cur;
    cur = SHADOW ? m_stg[c][v] : m_act[c][v];
    if (hi) cur = (cur % 256) + ((b * 256) & MASK);
    else    cur = (cur / 256) * 256 + b;
    if (SHADOW) m_stg[c][v] = cur;
    else        m_act[c][v] = cur;
  endtask

  task automatic model_edge(input logic rd, input logic wr, input logic [5:0] a,
                            input logic [7:0] dw, input logic [NC-1:0] evt);
    int c, off, b;
    int set_b [NC];
    int new_cr [NC];
    int clr;
    c = int'(a[5:4]); off = int'(a[3:0]); b = int'(dw); clr = 0;
    if (rd) m_rd = (c < NC) ? m_read(c, off) : 0;
    for (int k = 0; k < NC; k++) begin
      set_b[k] = evt[k] ? 1 : 0;
      new_cr[k] = 0;
      if (SHADOW && (m_en[k] == 0 || evt[k] || m_cr[k] == 1)) begin
        for (int v = 0; v < 3; v++) m_act[k][v] = m_stg[k][v];
        if (m_en[k] == 1) set_b[k] = set_b[k] + 2;
      end
    end
    if (wr && c < NC) begin
      case (off)
        0: m_wr(c, 0, 1'b0, b);
        1: m_wr(c, 0, 1'b1, b);
        2: m_en[c] = b % 2;
        3: m_wr(c, 1, 1'b0, b);
        4: m_wr(c, 1, 1'b1, b);
        5: m_wr(c, 2, 1'b0, b);
        6: m_wr(c, 2, 1'b1, b);
        7: new_cr[c] = b % 2;
        10: m_pre[c] = b;
        11: m_ud[c] = b % 2;
        12: m_pwm[c] = b % 2;
        13: m_fn[c] = b;
        14: clr = b % 4;
        15: m_mask[c] = b % 4;
        default: ;
      endcase
    end
    for (int k = 0; k < NC; k++) begin
      if (k == c) m_st[k] = (m_st[k] & ~clr) | set_b[k];
      else        m_st[k] = m_st[k] | set_b[k];
      m_cr[k] = new_cr[k];
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [NC*CW-1:0] ep, e1, e2;
    logic [NC-1:0]    een, ecr, eud, epw;
    logic [NC*8-1:0]  epre, efn;
    logic             eirq;
    eirq = 1'b0;
    for (int k = 0; k < NC; k++) begin
      ep[k*CW +: CW]  = CW'(m_act[k][0]);
      e1[k*CW +: CW]  = CW'(m_act[k][1]);
      e2[k*CW +: CW]  = CW'(m_act[k][2]);
      een[k] = m_en[k] == 1; ecr[k] = m_cr[k] == 1; eud[k] = m_ud[k] == 1; epw[k] = m_pwm[k] == 1;
      epre[k*8 +: 8] = 8'(m_pre[k]);
      efn[k*8 +: 8]  = 8'(m_fn[k]);
      if ((m_st[k] & m_mask[k]) != 0) eirq = 1'b1;
    end
    chk("data_read", bus.data_read, 64'(m_rd));
    chk("irq", irq, eirq);
    chk("period", period, ep);
    chk("compare1", compare1, e1);
    chk("compare2", compare2, e2);
    chk("en", en, een);
    chk("count_reset", count_reset, ecr);
    chk("upnotdown", upnotdown, eud);
    chk("pwm_en", pwm_en, epw);
    chk("prescale", prescale, epre);
    chk("functions", functions, efn);
  endtask

  // Driver: called at a falling edge, drives one cycle of bus/event inputs.
  task automatic step(input logic rd, input logic wr, input logic [5:0] a,
                      input logic [7:0] dw, input logic [NC-1:0] evt);
    bus.read = rd; bus.write = wr; bus.addr = a; bus.data_write = dw; period_evt = evt;
    @(posedge clk);
    model_edge(rd, wr, a, dw, evt);
    #1;
    check_outputs();
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0; period_evt = '0;
  endtask

  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.data_write = '0;
    period_evt = '0;
    counter_val = {12'hA5C, 12'h3B7};
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    for (int a = 0; a < 32; a++) begin
      step(1'b1, 1'b0, 6'(a), 8'h00, 2'b00);
      chk("reset_read", bus.data_read, (a % 16 == 11) ? 64'h01 : (a % 16 == 8 || a % 16 == 9) ? 64'(m_rd) : 64'h00);
    end

    step(1'b0, 1'b1, 6'h10, 8'h34, 2'b00);
    step(1'b0, 1'b1, 6'h11, 8'h12, 2'b00);
    step(1'b0, 1'b0, 6'h00, 8'h00, 2'b00);
    chk("ch1_period", period[CW +: CW], 64'h234);
    chk("ch0_period", period[CW-1:0], 64'h0);
    step(1'b1, 1'b0, 6'h11, 8'h00, 2'b00);
    chk("ch1_period_hi_rd", bus.data_read, 64'h02);

    step(1'b0, 1'b1, 6'h02, 8'h01, 2'b00);
    step(1'b0, 1'b1, 6'h03, 8'h80, 2'b00);
    step(1'b0, 1'b0, 6'h00, 8'h00, 2'b00);
    chk("cmp1_before_evt", compare1[CW-1:0], SHADOW ? 64'h000 : 64'h080);
    step(1'b0, 1'b0, 6'h00, 8'h00, 2'b01);
    chk("cmp1_after_evt", compare1[CW-1:0], 64'h080);
    step(1'b1, 1'b0, 6'h0E, 8'h00, 2'b00);
    chk("status_set", bus.data_read, SHADOW ? 64'h03 : 64'h01);
    step(1'b0, 1'b1, 6'h0E, 8'h01, 2'b00);
    step(1'b1, 1'b0, 6'h0E, 8'h00, 2'b00);
    chk("status_w1c", bus.data_read, SHADOW ? 64'h02 : 64'h00);

    step(1'b0, 1'b1, 6'h07, 8'h01, 2'b00);
    chk("count_reset_pulse", count_reset, 64'b01);
    step(1'b1, 1'b0, 6'h07, 8'h00, 2'b00);
    chk("count_reset_drop", count_reset, 64'b00);
    step(1'b0, 1'b0, 6'h00, 8'h00, 2'b00);
    chk("count_reset_rd", bus.data_read, 64'h00);

    step(1'b0, 1'b1, 6'h1F, 8'h01, 2'b00);
    step(1'b0, 1'b0, 6'h00, 8'h00, 2'b10);
    chk("irq_set", irq, 64'h1);
    step(1'b0, 1'b1, 6'h1E, 8'h01, 2'b10);
    chk("irq_set_wins", irq, 64'h1);
    step(1'b1, 1'b0, 6'h1E, 8'h00, 2'b00);
    chk("status_set_wins", bus.data_read[0], 64'h1);

    step(1'b0, 1'b1, 6'h32, 8'hFF, 2'b00);
    step(1'b1, 1'b0, 6'h32, 8'h00, 2'b00);
    chk("bad_channel_rd", bus.data_read, 64'h00);
    step(1'b0, 1'b1, 6'h01, 8'hFF, 2'b00);
    step(1'b1, 1'b0, 6'h01, 8'h00, 2'b00);
    chk("hi_byte_zero_ext", bus.data_read, 64'h0F);

    step(1'b1, 1'b1, 6'h0A, 8'h5A, 2'b00);
    chk("rd_before_wr", bus.data_read, 64'h00);
    step(1'b1, 1'b0, 6'h0A, 8'h00, 2'b00);
    chk("rd_after_wr", bus.data_read, 64'h5A);

    step(1'b0, 1'b1, 6'h17, 8'h01, 2'b00);
    chk("ch1_count_reset", count_reset, 64'b10);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) counter_val = NC*CW'($urandom);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
           8'($urandom), 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
